// File: rtl/result_display.sv
// Eight-digit multiplexed hex display for a 32-bit result word.
// Scans digit slots of DIV cycles each, with a leading all-anodes-off guard window per slot.
module result_display #(
    parameter int DIV   = 50000,
    parameter int GUARD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] result,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        slot_wrap
);

    localparam logic [15:0] LAST    = 16'(DIV - 1);
    localparam logic [15:0] GUARD_C = 16'(GUARD);

    logic [31:0] shadow;
    logic [15:0] counter;
    logic [2:0]  index;

    logic [31:0] upper;
    logic [3:0]  nibble;
    logic        in_guard;
    logic        blank;
    logic        slot_end;
    logic [6:0]  glyph;

    // upper holds the current digit and every digit to its left, so a zero
    // value means the current digit is a leading zero.
    always_comb begin
        upper    = shadow >> {index, 2'b00};
        nibble   = upper[3:0];
        in_guard = (counter < GUARD_C);
        blank    = blank_lz && (index != 3'd0) && (upper == 32'd0);
        slot_end = (counter == LAST);
        glyph    = 7'h7F;
        case (nibble)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
    end

    // Outputs are registered from the pre-edge counter/index/shadow, so they
    // trail the scan state by one cycle; slot_wrap marks the first cycle of digit 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow    <= 32'd0;
            counter   <= 16'd0;
            index     <= 3'd0;
            an        <= 8'hFF;
            seg       <= 7'h7F;
            dp        <= 1'b1;
            slot_wrap <= 1'b0;
        end else begin
            if (load) begin
                shadow <= result;
            end
            if (slot_end) begin
                counter <= 16'd0;
                index   <= index + 3'd1;
            end else begin
                counter <= counter + 16'd1;
            end
            an        <= in_guard ? 8'hFF : ~(8'd1 << index);
            seg       <= blank ? 7'h7F : glyph;
            dp        <= ~(dp_mask[index] && !in_guard);
            slot_wrap <= slot_end && (index == 3'd7);
        end
    end

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display (DIV=8, GUARD=2): digit tables, a
// time-based reference model, and hand sequences for wrap-load and async reset.
module tb_result_display;

    localparam int DIV   = 8;
    localparam int GUARD = 2;
    localparam int FRAME = 8 * DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] result = 32'd0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [7:0]  dp_mask = 8'd0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        slot_wrap;

    result_display #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk(clk), .reset(reset), .result(result), .load(load),
        .blank_lz(blank_lz), .dp_mask(dp_mask), .an(an), .seg(seg),
        .dp(dp), .slot_wrap(slot_wrap)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: edges since reset and the value last captured.
    int          t;
    logic [31:0] shadow_m;
    int          cur_idx;
    int          cur_phase;

    logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [31:0]     value;
        logic            blz;
        logic [7:0][6:0] digits;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
        end
    endtask

    // Predict the outputs of the coming edge from time and captured value, then compare.
    task automatic tick();
        logic [7:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic        e_wrap;
        logic [31:0] up;
        int          idx;
        int          phase;
        phase  = t % DIV;
        idx    = (t / DIV) % 8;
        up     = shadow_m >> (4 * idx);
        e_an   = (phase < GUARD) ? 8'hFF : ~(8'h01 << idx);
        e_seg  = (blank_lz && idx != 0 && up == 32'd0) ? 7'h7F : seg_lut[up[3:0]];
        e_dp   = !(dp_mask[idx] && phase >= GUARD);
        e_wrap = (t % FRAME) == FRAME - 1;
        if (load) shadow_m = result;
        t++;
        cur_idx   = idx;
        cur_phase = phase;
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("slot_wrap", 32'(slot_wrap), 32'(e_wrap));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, 32'(an), 32'hFF);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_dp"}, 32'(dp), 32'h1);
        check({tag, "_wrap"}, 32'(slot_wrap), 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        reset    = 1'b1;
        t        = 0;
        shadow_m = 32'd0;
    endtask

    task automatic run_until_frame_pos(input int pos);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (t % FRAME == pos) return;
            tick();
        end
        check("reach_pos", 32'(t % FRAME), 32'(pos));
    endtask

    initial begin
        int wraps;
        vecs[0] = '{32'h1234ABCD, 1'b0,
                    {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21}};
        vecs[1] = '{32'h000000F0, 1'b1,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h0E, 7'h40}};
        vecs[2] = '{32'h00000000, 1'b1,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{32'h00000000, 1'b0,
                    {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[4] = '{32'h00F00A00, 1'b1,
                    {7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40, 7'h08, 7'h40, 7'h40}};

        #1;
        do_reset();

        // Digit tables: one full frame per vector after a single load.
        foreach (vecs[v]) begin
            do_reset();
            result   = vecs[v].value;
            blank_lz = vecs[v].blz;
            dp_mask  = 8'h00;
            load     = 1'b1;
            tick();
            load   = 1'b0;
            result = $urandom;
            for (int i = 0; i < FRAME + 4; i++) begin
                tick();
                if (cur_phase >= GUARD)
                    check("digit", 32'(seg), 32'(vecs[v].digits[cur_idx]));
            end
        end

        // Decimal points on digits 0 and 2; one wrap pulse per frame.
        do_reset();
        blank_lz = 1'b0;
        dp_mask  = 8'h05;
        result   = 32'h1234ABCD;
        load     = 1'b1;
        tick();
        load  = 1'b0;
        wraps = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (slot_wrap) wraps++;
        end
        check("wrap_count", 32'(wraps), 32'd2);

        // Load on the exact wrap edge, then a changing result with load low.
        run_until_frame_pos(FRAME - 1);
        result = 32'h9E5C_07B1;
        load   = 1'b1;
        tick();
        check("wrap_on_load", 32'(slot_wrap), 32'h1);
        load = 1'b0;
        for (int i = 0; i < FRAME + 8; i++) begin
            result  = $urandom;
            dp_mask = 8'($urandom_range(0, 255));
            tick();
        end

        // Asynchronous reset at cycle 3 of slot 5, then restart from digit 0.
        dp_mask = 8'h01;
        run_until_frame_pos(5 * DIV + 3);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        reset    = 1'b1;
        t        = 0;
        shadow_m = 32'd0;
        for (int i = 0; i < 2 * DIV; i++) tick();

        // Random stimulus against the reference model.
        for (int i = 0; i < 600; i++) begin
            result   = $urandom;
            load     = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) result = result & 32'h0000_0FFF;
            blank_lz = 1'($urandom_range(0, 1));
            dp_mask  = 8'($urandom_range(0, 255));
            tick();
        end
        load = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
